sbus_rd_master: RTL and testbench

SBUS_RD_MASTER -- requirements
Module: sbus_rd_master

---
 rtl/sbus_rd_master_pkg.sv | 28 ++
 rtl/sbus_rd_master_edge.sv | 20 ++
 rtl/sbus_rd_master.sv | 146 ++++++++++++++
 tb/tb_sbus_rd_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sbus_rd_master_pkg.sv
// Shared SBUS read-master definitions: FSM state type, timeout defaults, and
// helpers for picking words out of a request mask.
package sbus_rd_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRT = 2'd1,
    XFER = 2'd2,
    FIN  = 2'd3
  } tSbusRdState;

  localparam int ACK_TIMEOUT_DEF   = 64;
  localparam int VALID_TIMEOUT_DEF = 128;

  // Masks use PDP-10 bit order: word index k lives at vector bit 3-k.
  function automatic logic [1:0] low_k(input logic [3:0] m);
    logic [1:0] k_r;
    k_r = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[3-k]) k_r = 2'(k);
    return k_r;
  endfunction

  function automatic logic [3:0] k_bit(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction

endpackage

// File: rtl/sbus_rd_master_edge.sv
// Rising-edge detector for the SBUS handshake lines (ACKN, DATA_VALID).
module sbus_edge_det #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/sbus_rd_master.sv
// SBUS read master: issues one START per request, tracks ACKN and DATA_VALID
// edges per requested word, returns words to the client, aborts on timeout.
module sbus_rd_master
  import sbus_rd_master_pkg::*;
#(
  parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
  parameter int VALID_TIMEOUT = VALID_TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [21:0] REQ_ADR,   // [21:0] = PDP bits 14:35
  input  logic [3:0]  REQ_RQ,    // [3:0]  = PDP bits 0:3
  output logic        READY,
  output logic        START,
  output logic [21:0] ADR,
  output logic [3:0]  RQ,
  input  logic        ACKN,
  input  logic        DATA_VALID,
  input  logic [35:0] D,
  output logic        WD_VALID,
  output logic [35:0] WD_DATA,
  output logic [1:0]  WD_OFS,
  output logic        DONE,
  output logic        NXM
);

  localparam int TMAX  = (ACK_TIMEOUT > VALID_TIMEOUT) ? ACK_TIMEOUT : VALID_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 2);

  tSbusRdState      state_q, state_d;
  logic [21:0]      adr_q, adr_d;
  logic [3:0]       rq_q, rq_d, ack_left_q, ack_left_d, rd_left_q, rd_left_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wd_valid_q, wd_valid_d, nxm_q, nxm_d;
  logic [35:0]      wd_data_q, wd_data_d;
  logic [1:0]       wd_ofs_q, wd_ofs_d, rd_k;
  logic [1:0]       rise;
  logic             ack_hit, dv_hit, busy;

  sbus_edge_det #(.W(2)) u_edge (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .sig_i  ({ACKN, DATA_VALID}),
    .rise_o (rise)
  );

  // Edges only count while a transfer owns the bus and a word is still owed.
  assign busy    = (state_q == STRT) || (state_q == XFER);
  assign ack_hit = busy && rise[1] && (ack_left_q != 4'd0);
  assign dv_hit  = busy && rise[0] && (rd_left_q != 4'd0);
  assign rd_k    = low_k(rd_left_q);

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rq_d       = rq_q;
    ack_left_d = ack_left_q;
    rd_left_d  = rd_left_q;
    cnt_d      = cnt_q;
    wd_valid_d = 1'b0;
    wd_data_d  = wd_data_q;
    wd_ofs_d   = wd_ofs_q;
    nxm_d      = 1'b0;

    if (ack_hit) ack_left_d = ack_left_q & ~k_bit(low_k(ack_left_q));
    if (dv_hit) begin
      rd_left_d  = rd_left_q & ~k_bit(rd_k);
      wd_valid_d = 1'b1;
      wd_data_d  = D;
      wd_ofs_d   = adr_q[1:0] + rd_k;
    end

    case (state_q)
      IDLE: if (REQ) begin
        if (REQ_RQ != 4'd0) begin
          adr_d      = REQ_ADR;
          rq_d       = REQ_RQ;
          ack_left_d = REQ_RQ;
          rd_left_d  = REQ_RQ;
          state_d    = STRT;
        end else begin
          state_d = FIN;
        end
      end
      STRT: begin
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        cnt_d = (ack_hit || dv_hit) ? '0 : cnt_q + CNT_W'(1);
        if (!ack_hit && !dv_hit &&
            (((ack_left_q != 4'd0) && (cnt_q == CNT_W'(ACK_TIMEOUT))) ||
             ((ack_left_q == 4'd0) && (rd_left_q != 4'd0) &&
              (cnt_q == CNT_W'(VALID_TIMEOUT))))) begin
          nxm_d      = 1'b1;
          ack_left_d = 4'd0;
          rd_left_d  = 4'd0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if ((ack_left_q == 4'd0) && (rd_left_q == 4'd0) && !ACKN && !DATA_VALID) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      rq_q       <= '0;
      ack_left_q <= '0;
      rd_left_q  <= '0;
      cnt_q      <= '0;
      wd_valid_q <= 1'b0;
      wd_data_q  <= '0;
      wd_ofs_q   <= '0;
      nxm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rq_q       <= rq_d;
      ack_left_q <= ack_left_d;
      rd_left_q  <= rd_left_d;
      cnt_q      <= cnt_d;
      wd_valid_q <= wd_valid_d;
      wd_data_q  <= wd_data_d;
      wd_ofs_q   <= wd_ofs_d;
      nxm_q      <= nxm_d;
    end
  end

  assign READY    = (state_q == IDLE);
  assign START    = (state_q == STRT);
  assign DONE     = (state_q == FIN);
  assign ADR      = adr_q;
  assign RQ       = rq_q;
  assign WD_VALID = wd_valid_q;
  assign WD_DATA  = wd_data_q;
  assign WD_OFS   = wd_ofs_q;
  assign NXM      = nxm_q;

endmodule

// File: tb/tb_sbus_rd_master.sv
// Directed bench for sbus_rd_master: hand-sequenced memory responses with
// expected offsets, data, strobes and timeout cycles written out per case.
module tb_sbus_rd_master;

  localparam int ACK_TO = 8;
  localparam int VAL_TO = 12;

  logic        CLK = 1'b0, RESET = 1'b1, REQ = 1'b0, ACKN = 1'b0, DATA_VALID = 1'b0;
  logic [21:0] REQ_ADR = '0;
  logic [3:0]  REQ_RQ = '0;
  logic [35:0] D = '0;
  logic        READY, START, WD_VALID, DONE, NXM;
  logic [21:0] ADR;
  logic [3:0]  RQ;
  logic [35:0] WD_DATA;
  logic [1:0]  WD_OFS;

  int n_tests = 0, n_fail = 0;
  int start_cnt = 0, wdv_cnt = 0, done_cnt = 0, nxm_cnt = 0;
  int s0, w0, d0, n0;

  sbus_rd_master #(.ACK_TIMEOUT(ACK_TO), .VALID_TIMEOUT(VAL_TO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_ADR(REQ_ADR), .REQ_RQ(REQ_RQ),
    .READY(READY), .START(START), .ADR(ADR), .RQ(RQ),
    .ACKN(ACKN), .DATA_VALID(DATA_VALID), .D(D),
    .WD_VALID(WD_VALID), .WD_DATA(WD_DATA), .WD_OFS(WD_OFS),
    .DONE(DONE), .NXM(NXM)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (START)    start_cnt++;
    if (WD_VALID) wdv_cnt++;
    if (DONE)     done_cnt++;
    if (NXM)      nxm_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [35:0] memw(input logic [21:0] a);
    return {14'h2A5A, a} ^ 36'h0_F0F0_0000;
  endfunction

  task automatic snap();
    s0 = start_cnt; w0 = wdv_cnt; d0 = done_cnt; n0 = nxm_cnt;
  endtask

  task automatic issue(input logic [21:0] a, input logic [3:0] m);
    REQ = 1'b1; REQ_ADR = a; REQ_RQ = m;
    step();
    REQ = 1'b0;
  endtask

  task automatic ack();
    ACKN = 1'b1; step(); ACKN = 1'b0; step();
  endtask

  task automatic word(input string tag, input logic [21:0] a, input logic [1:0] ofs);
    DATA_VALID = 1'b1; D = memw(a);
    step();
    chk({tag, " wdv"}, WD_VALID, 1'b1);
    chk({tag, " ofs"}, WD_OFS, ofs);
    chk({tag, " data"}, WD_DATA, memw(a));
    DATA_VALID = 1'b0; D = '0;
    step();
    chk({tag, " wdv low"}, WD_VALID, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ready"}, READY, 1'b1);
    chk({tag, " start"}, START, 1'b0);
    chk({tag, " adr"}, ADR, 22'd0);
    chk({tag, " rq"}, RQ, 4'd0);
    chk({tag, " wdv"}, WD_VALID, 1'b0);
    chk({tag, " wdd"}, WD_DATA, 36'd0);
    chk({tag, " ofs"}, WD_OFS, 2'd0);
    chk({tag, " done"}, DONE, 1'b0);
    chk({tag, " nxm"}, NXM, 1'b0);
  endtask

  initial begin
    step(); step();
    chk_reset_outs("reset");
    RESET = 1'b0;
    step();

    // four words from quadword 0o1000, offsets in order
    snap();
    issue(22'o1000, 4'b1111);
    chk("q4 start", START, 1'b1);
    chk("q4 ready", READY, 1'b0);
    chk("q4 adr", ADR, 22'o1000);
    chk("q4 rq", RQ, 4'b1111);
    step();
    chk("q4 start drop", START, 1'b0);
    repeat (4) ack();
    word("q4 w0", 22'o1000, 2'd0);
    word("q4 w1", 22'o1001, 2'd1);
    word("q4 w2", 22'o1002, 2'd2);
    word("q4 w3", 22'o1003, 2'd3);
    chk("q4 done", DONE, 1'b1);
    chk("q4 adr hold", ADR, 22'o1000);
    step();
    chk("q4 done pulse", DONE, 1'b0);
    chk("q4 ready back", READY, 1'b1);
    chk("q4 starts", start_cnt - s0, 1);
    chk("q4 wdvs", wdv_cnt - w0, 4);

    // sparse mask with wrap: k=0 -> offset 2, k=2 -> offset 0
    snap();
    issue(22'o1002, 4'b1010);
    step();
    ack(); ack();
    word("sp w0", 22'o1002, 2'd2);
    word("sp w1", 22'o1000, 2'd0);
    chk("sp done", DONE, 1'b1);
    step();
    chk("sp wdvs", wdv_cnt - w0, 2);
    chk("sp dones", done_cnt - d0, 1);

    // empty mask: REQ in cycle 1, DONE in cycle 2, never START
    snap();
    issue(22'o5000, 4'b0000);
    chk("empty done", DONE, 1'b1);
    chk("empty ready", READY, 1'b0);
    step();
    chk("empty done pulse", DONE, 1'b0);
    chk("empty starts", start_cnt - s0, 0);

    // no ACKN at all: NXM in XFER cycle ACK_TO+1
    snap();
    issue(22'o2000, 4'b1111);
    step();
    repeat (ACK_TO) step();
    chk("ackto early nxm", nxm_cnt - n0, 0);
    step();
    chk("ackto nxm", NXM, 1'b1);
    chk("ackto ready", READY, 1'b1);
    step();
    chk("ackto nxm pulse", NXM, 1'b0);
    chk("ackto dones", done_cnt - d0, 0);

    // acked but no data: NXM VAL_TO+1 cycles after the ack edge
    snap();
    issue(22'o2100, 4'b1000);
    step();
    ACKN = 1'b1; step(); ACKN = 1'b0;
    repeat (VAL_TO) step();
    chk("valto early nxm", nxm_cnt - n0, 0);
    step();
    chk("valto nxm", NXM, 1'b1);
    chk("valto dones", done_cnt - d0, 0);
    step();

    // reset mid-transfer, later data ignored
    snap();
    issue(22'o3000, 4'b1111);
    step();
    repeat (4) ack();
    word("rst w0", 22'o3000, 2'd0);
    word("rst w1", 22'o3001, 2'd1);
    RESET = 1'b1;
    step();
    chk_reset_outs("midrst");
    RESET = 1'b0;
    DATA_VALID = 1'b1; D = memw(22'o3002); step();
    DATA_VALID = 1'b0; step();
    DATA_VALID = 1'b1; D = memw(22'o3003); step();
    DATA_VALID = 1'b0; step(); step();
    chk("midrst wdvs", wdv_cnt - w0, 2);
    chk("midrst dones", done_cnt - d0, 0);
    chk("midrst nxms", nxm_cnt - n0, 0);

    // ACKN and DATA_VALID rise together
    snap();
    issue(22'o4001, 4'b1100);
    step();
    ACKN = 1'b1; DATA_VALID = 1'b1; D = memw(22'o4001);
    step();
    chk("same wdv0", WD_VALID, 1'b1);
    chk("same ofs0", WD_OFS, 2'd1);
    ACKN = 1'b0; DATA_VALID = 1'b0;
    step();
    ACKN = 1'b1; DATA_VALID = 1'b1; D = memw(22'o4002);
    step();
    chk("same ofs1", WD_OFS, 2'd2);
    chk("same data1", WD_DATA, memw(22'o4002));
    ACKN = 1'b0; DATA_VALID = 1'b0;
    step();
    chk("same done", DONE, 1'b1);
    step();
    chk("same wdvs", wdv_cnt - w0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
